fp32_to_int_converter: RTL and testbench
========================================

# fp32_to_int_converter

Pipelined IEEE-754 binary32 to 32-bit integer converter for the FPU datapath. It is the reverse of the integer-to-float path: that path counts leading zeros and normalizes, while this block denormalizes by shifting the significand right by the exponent distance. It supports signed and unsigned targets, round-toward-zero and round-to-nearest-even, saturation and exception flags. It sits between the FPU operand registers and the integer writeback, with valid/ready handshakes on both sides.

## Interface
- Parameters: none. The format is fixed: binary32 in, 32-bit integer out.
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input operand valid
- in_ready  out  1  converter can accept an operand this cycle
- in_data  in  32  binary32 operand {sign, exp[7:0], frac[22:0]}
- in_signed  in  1  1 = int32 target, 0 = uint32 target
- in_rm  in  1  0 = round toward zero (RTZ), 1 = round to nearest, ties to even (RNE)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_data  out  32  integer result
- out_invalid  out  1  NaN, infinity, or out-of-range operand
- out_inexact  out  1  result differs from the operand value (never set together with out_invalid)

## Operation
- Transfer rule: a transfer occurs when valid and ready are both high at a rising edge.
- Pipeline: two stages with one global advance enable, en = ~out_valid | out_ready. in_ready = en.
- Stage 1 (unpack):
  - m = {exp != 0, frac}, 24 bits.
  - E = exp - 127.
  - Latch sign, in_signed, in_rm, and the NaN, infinity and zero/denormal classifications.
- Stage 2 (shift, round, saturate):
  - E >= 23: magnitude = m << (E-23). No fraction bits.
  - 0 <= E < 23: integer part = m >> (23-E). Guard bit = first dropped bit. Sticky = OR of the remaining dropped bits.
  - E < 0, including denormals: integer part = 0. For E = -1, guard = 1 and sticky = |frac. For E <= -2 or a nonzero denormal, guard = 0 and sticky = 1.
  - RNE increments when guard & (sticky | lsb). RTZ never increments.
  - Rounding overflow is impossible for 32 bits, because fraction bits exist only when magnitude < 2^24.
  - Zero or ±0 → 0, no flags.
- Saturation, signed target (in order):
  - NaN → 0x7FFFFFFF, invalid.
  - Negative with E >= 31, except exactly -2^31 → 0x80000000, invalid.
  - Positive with E >= 31 → 0x7FFFFFFF, invalid.
  - -2^31 exactly (0xCF000000) → 0x80000000, no flags.
  - Otherwise two's-complement of the rounded magnitude.
- Saturation, unsigned target:
  - NaN or positive with E >= 32 → 0xFFFFFFFF, invalid.
  - Negative value whose rounded magnitude is nonzero (including -inf) → 0x00000000, invalid.
  - Negative value rounding to 0 → 0x00000000, inexact if nonzero.
- Flags: inexact = (guard | sticky) & ~invalid.

## Timing
- Reset: out_valid = 0, out_data = 0, out_invalid = 0, out_inexact = 0, internal stage valid = 0. Assertion at any time discards in-flight operands, with no partial outputs after release.
- Latency: an operand accepted at edge N appears with out_valid = 1 after edge N+2 when no stall occurs.
- Throughput: one result per cycle while out_ready = 1.
- Stall: out_valid & ~out_ready freezes both stages. out_data and the flags hold stable, and in_ready = 0 in the same cycle (combinational from out_ready and out_valid).
- Bubbles: when in_valid = 0 at an advancing edge, a bubble propagates and out_valid drops accordingly.
- Simultaneous accept and output transfer in one cycle is legal with no loss.
- in_signed and in_rm are sampled only at input transfer.

## Test plan
- RTZ, signed:
  - 0x3FC00000 (1.5) → 1, inexact.
  - 0xBE99999A (-0.3) → 0, inexact.
  - 0x00000001 (denormal) → 0, inexact.
  - 0x80000000 (-0) → 0, no flags.
- RNE, signed:
  - 0x3F000000 (0.5) → 0, inexact.
  - 0x40200000 (2.5) → 2, inexact.
  - 0x40600000 (3.5) → 4, inexact.
  - 0x3FC00000 (1.5) → 2, inexact.
- Signed limits:
  - 0xCF000000 → 0x80000000, no flags.
  - 0x4F000000 → 0x7FFFFFFF, invalid.
  - 0x7FC00000 (NaN) → 0x7FFFFFFF, invalid.
  - 0xFF800000 (-inf) → 0x80000000, invalid.
- Unsigned:
  - 0x4F000000 → 0x80000000, no flags.
  - 0x4F800000 (2^32) → 0xFFFFFFFF, invalid.
  - 0xBF800000 (-1.0) → 0, invalid.
  - 0xBE99999A RTZ → 0, inexact.
  - 0xBF400000 (-0.75) RNE → 0, invalid.
- Backpressure: drive 6 back-to-back operands with out_ready low for 3 cycles mid-stream. Expected:
  - in_ready drops and outputs hold stable during the stall.
  - All 6 results arrive in order with no duplicates.
  - Throughput returns to 1 per cycle.
- Reset: assert rst_n low with 2 operands in flight. Expected:
  - out_valid = 0 and outputs = 0 immediately (asynchronous).
  - After release, the first new operand appears 2 cycles after acceptance.
  - No stale results.

Source files
------------

// File: rtl/fp32_to_int_converter.sv
// Two-stage binary32 -> int32/uint32 converter: unpack, then denormalize/round/saturate.
// RTZ and RNE rounding, invalid/inexact flags, valid/ready on both sides with one global advance enable.
module fp32_to_int_converter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_signed,
    input  logic        in_rm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_invalid,
    output logic        out_inexact
);

    localparam int unsigned MANT_W = 24;
    localparam int unsigned EXP_W  = 8;
    localparam int unsigned DATA_W = 32;

    logic en;

    // Stage 1 registers
    logic              s1_valid_q;
    logic              s1_sign_q;
    logic              s1_signed_q;
    logic              s1_rm_q;
    logic              s1_nan_q;
    logic              s1_inf_q;
    logic              s1_zero_q;
    logic              s1_denorm_q;
    logic [EXP_W-1:0]  s1_exp_q;
    logic [MANT_W-1:0] s1_m_q;

    // Stage 2 (output) registers
    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic              out_invalid_q;
    logic              out_inexact_q;

    // Stage 2 combinational results
    logic signed [9:0] e;
    logic [4:0]        sh;
    logic [3:0]        lsh;
    logic [DATA_W-1:0] mag;
    logic [DATA_W-1:0] rmag;
    logic              guard;
    logic              sticky;
    logic              inc;
    logic [DATA_W-1:0] out_data_d;
    logic              out_invalid_d;
    logic              out_inexact_d;

    logic [EXP_W-1:0]  in_exp;
    logic [22:0]       in_frac;

    assign en       = ~out_valid_q | out_ready;
    assign in_ready = en;
    assign in_exp   = in_data[30:23];
    assign in_frac  = in_data[22:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_signed_q <= 1'b0;
            s1_rm_q     <= 1'b0;
            s1_nan_q    <= 1'b0;
            s1_inf_q    <= 1'b0;
            s1_zero_q   <= 1'b0;
            s1_denorm_q <= 1'b0;
            s1_exp_q    <= '0;
            s1_m_q      <= '0;
        end else if (en) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_sign_q   <= in_data[31];
                s1_signed_q <= in_signed;
                s1_rm_q     <= in_rm;
                s1_nan_q    <= (in_exp == 8'hFF) && (in_frac != 23'd0);
                s1_inf_q    <= (in_exp == 8'hFF) && (in_frac == 23'd0);
                s1_zero_q   <= (in_exp == 8'h00) && (in_frac == 23'd0);
                s1_denorm_q <= (in_exp == 8'h00) && (in_frac != 23'd0);
                s1_exp_q    <= in_exp;
                s1_m_q      <= {in_exp != 8'h00, in_frac};
            end
        end
    end

    // Denormalize by the exponent distance, then round and saturate
    always_comb begin
        sh            = '0;
        lsh           = '0;
        mag           = '0;
        guard         = 1'b0;
        sticky        = 1'b0;
        out_data_d    = '0;
        out_invalid_d = 1'b0;
        out_inexact_d = 1'b0;
        e             = $signed({2'b00, s1_exp_q}) - 10'sd127;

        if (s1_zero_q) begin
            sticky = 1'b0;
        end else if (s1_denorm_q || (e <= -10'sd2)) begin
            sticky = 1'b1;
        end else if (e == -10'sd1) begin
            guard  = 1'b1;
            sticky = |s1_m_q[22:0];
        end else if (e < 10'sd23) begin
            sh     = 5'(10'sd23 - e);
            mag    = DATA_W'(s1_m_q >> sh);
            guard  = s1_m_q[sh - 5'd1];
            sticky = |(s1_m_q & ((24'd1 << (sh - 5'd1)) - 24'd1));
        end else if (e <= 10'sd31) begin
            lsh = 4'(e - 10'sd23);
            mag = DATA_W'(s1_m_q) << lsh;
        end

        inc  = s1_rm_q & guard & (sticky | mag[0]);
        rmag = mag + DATA_W'(inc);

        if (s1_signed_q) begin
            if (s1_nan_q) begin
                out_data_d    = 32'h7FFF_FFFF;
                out_invalid_d = 1'b1;
            end else if (e >= 10'sd31) begin
                // Only exactly -2^31 fits; every other large operand saturates
                if (s1_sign_q) begin
                    out_data_d    = 32'h8000_0000;
                    out_invalid_d = !((e == 10'sd31) && (s1_m_q == 24'h80_0000));
                end else begin
                    out_data_d    = 32'h7FFF_FFFF;
                    out_invalid_d = 1'b1;
                end
            end else begin
                out_data_d = s1_sign_q ? (32'd0 - rmag) : rmag;
            end
        end else begin
            if (s1_nan_q || (!s1_sign_q && (e >= 10'sd32))) begin
                out_data_d    = 32'hFFFF_FFFF;
                out_invalid_d = 1'b1;
            end else if (s1_sign_q) begin
                out_data_d    = '0;
                out_invalid_d = (e >= 10'sd32) || (rmag != 32'd0);
            end else begin
                out_data_d = rmag;
            end
        end

        out_inexact_d = (guard | sticky) & ~out_invalid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_invalid_q <= 1'b0;
            out_inexact_q <= 1'b0;
        end else if (en) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_data_q    <= out_data_d;
                out_invalid_q <= out_invalid_d;
                out_inexact_q <= out_inexact_d;
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_invalid = out_invalid_q;
    assign out_inexact = out_inexact_q;

endmodule

// File: tb/tb_fp32_to_int_converter.sv
// Bench for fp32_to_int_converter: directed vectors, backpressure, reset, and
// random operands against an exact fixed-point reference model.
module tb_fp32_to_int_converter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_signed;
    logic        in_rm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_invalid;
    logic        out_inexact;

    fp32_to_int_converter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_signed   (in_signed),
        .in_rm       (in_rm),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_invalid (out_invalid),
        .out_inexact (out_inexact)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic        s;
        logic        rm;
        logic [31:0] r;
        logic        inv;
        logic        inx;
    } vec_t;

    vec_t dir [17] = '{
        '{32'h3FC00000, 1'b1, 1'b0, 32'h00000001, 1'b0, 1'b1},
        '{32'hBE99999A, 1'b1, 1'b0, 32'h00000000, 1'b0, 1'b1},
        '{32'h00000001, 1'b1, 1'b0, 32'h00000000, 1'b0, 1'b1},
        '{32'h80000000, 1'b1, 1'b0, 32'h00000000, 1'b0, 1'b0},
        '{32'h3F000000, 1'b1, 1'b1, 32'h00000000, 1'b0, 1'b1},
        '{32'h40200000, 1'b1, 1'b1, 32'h00000002, 1'b0, 1'b1},
        '{32'h40600000, 1'b1, 1'b1, 32'h00000004, 1'b0, 1'b1},
        '{32'h3FC00000, 1'b1, 1'b1, 32'h00000002, 1'b0, 1'b1},
        '{32'hCF000000, 1'b1, 1'b0, 32'h80000000, 1'b0, 1'b0},
        '{32'h4F000000, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0},
        '{32'h7FC00000, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0},
        '{32'hFF800000, 1'b1, 1'b0, 32'h80000000, 1'b1, 1'b0},
        '{32'h4F000000, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b0},
        '{32'h4F800000, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0},
        '{32'hBF800000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0},
        '{32'hBE99999A, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1},
        '{32'hBF400000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0}
    };

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          bp_lo   = 0;
    int          bp_hi   = 0;
    bit          rand_mode = 1'b0;
    bit          track_post = 1'b0;
    int          first_post = -1;
    int          last_post  = -1;
    int          n_post     = 0;
    logic [33:0] cur_exp;
    logic [33:0] q [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Exact value as fixed point with 160 fraction bits, rounded by comparison against one half
    function automatic logic [33:0] ref_conv(input logic [31:0] d, input logic sgn_t, input logic rne);
        logic         neg;
        logic [7:0]   ex;
        logic [22:0]  fr;
        logic         huge;
        logic [199:0] val;
        logic [159:0] fp;
        logic [159:0] half;
        logic [39:0]  ip;
        logic [39:0]  rnd;
        int           sc;
        neg  = d[31];
        ex   = d[30:23];
        fr   = d[22:0];
        if (ex == 8'hFF && fr != 23'd0)
            return sgn_t ? {32'h7FFFFFFF, 2'b10} : {32'hFFFFFFFF, 2'b10};
        huge = (ex == 8'hFF) || (int'(ex) - 127 >= 32);
        if (huge) begin
            if (sgn_t) return neg ? {32'h80000000, 2'b10} : {32'h7FFFFFFF, 2'b10};
            return neg ? {32'h00000000, 2'b10} : {32'hFFFFFFFF, 2'b10};
        end
        sc   = (ex == 8'h00) ? -126 : int'(ex) - 127;
        val  = 200'({ex != 8'h00, fr}) << (sc - 23 + 160);
        ip   = val[199:160];
        fp   = val[159:0];
        half = 160'd1 << 159;
        rnd  = ip + 40'((rne && ((fp > half) || (fp == half && ip[0]))) ? 1 : 0);
        if (sgn_t) begin
            if (neg) begin
                if (rnd > 40'h80000000) return {32'h80000000, 2'b10};
                return {32'(40'd0 - rnd), 1'b0, fp != 160'd0};
            end
            if (rnd > 40'h7FFFFFFF) return {32'h7FFFFFFF, 2'b10};
            return {rnd[31:0], 1'b0, fp != 160'd0};
        end
        if (neg) begin
            if (rnd != 40'd0) return {32'h0, 2'b10};
            return {32'h0, 1'b0, fp != 160'd0};
        end
        if (rnd > 40'hFFFFFFFF) return {32'hFFFFFFFF, 2'b10};
        return {rnd[31:0], 1'b0, fp != 160'd0};
    endfunction

    task automatic set_ready();
        if (rand_mode) out_ready = ($urandom_range(0, 9) < 7);
        else           out_ready = !(cyc >= bp_lo && cyc < bp_hi);
    endtask

    // One clock: score the output seen before the edge, then update the scoreboard
    task automatic step();
        logic acc;
        logic fire;
        acc  = in_valid & in_ready;
        fire = out_valid & out_ready;
        if (out_valid) begin
            if (q.size() == 0) check("no_stale_output", 64'(out_valid), 64'd0);
            else               check("result", 64'({out_data, out_invalid, out_inexact}), 64'(q[0]));
        end
        if (out_valid && !out_ready) check("stall_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        if (fire && q.size() > 0) begin
            void'(q.pop_front());
            if (track_post && cyc >= bp_hi) begin
                if (first_post < 0) first_post = cyc;
                last_post = cyc;
                n_post++;
            end
        end
        if (acc) q.push_back(cur_exp);
        cyc++;
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic s, input logic rm, input logic [33:0] e);
        bit done;
        done      = 1'b0;
        in_valid  = 1'b1;
        in_data   = d;
        in_signed = s;
        in_rm     = rm;
        cur_exp   = e;
        for (int k = 0; k < 64 && !done; k++) begin
            set_ready();
            #1;
            done = in_ready;
            step();
        end
        if (!done) check("accept_timeout", 64'(done), 64'd1);
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int k = 0; k < 64 && q.size() > 0; k++) begin
            set_ready();
            #1;
            step();
        end
        check("drain_empty", 64'(q.size()), 64'd0);
    endtask

    task automatic send_ref(input logic [31:0] d, input logic s, input logic rm);
        send(d, s, rm, ref_conv(d, s, rm));
    endtask

    function automatic logic [31:0] rand_fp();
        logic [7:0] ex;
        case ($urandom_range(0, 7))
            0:       ex = 8'h00;
            1:       ex = 8'hFF;
            default: ex = 8'($urandom_range(110, 160));
        endcase
        return {1'($urandom_range(0, 1)), ex, 23'($urandom)};
    endfunction

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_signed = 1'b0;
        in_rm     = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_flags", 64'({out_invalid, out_inexact}), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors with constant expectations
        foreach (dir[i]) send(dir[i].d, dir[i].s, dir[i].rm, {dir[i].r, dir[i].inv, dir[i].inx});
        drain();

        // Six back-to-back operands with a three-cycle stall in the middle
        bp_lo      = cyc + 3;
        bp_hi      = cyc + 6;
        track_post = 1'b1;
        for (int i = 0; i < 6; i++) send_ref(rand_fp(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        drain();
        track_post = 1'b0;
        check("bp_post_count", 64'(n_post), 64'd5);
        check("bp_post_back_to_back", 64'(last_post - first_post + 1), 64'(n_post));

        // Reset with two operands in flight
        send_ref(32'h40400000, 1'b1, 1'b0);
        send_ref(32'hC0A00000, 1'b1, 1'b0);
        in_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'd0);
        check("async_rst_data", 64'(out_data), 64'd0);
        check("async_rst_flags", 64'({out_invalid, out_inexact}), 64'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h41200000;
        in_signed = 1'b1;
        in_rm     = 1'b0;
        cur_exp   = {32'd10, 2'b00};
        #1;
        step();
        in_valid = 1'b0;
        check("lat_edge1_valid", 64'(out_valid), 64'd0);
        step();
        check("lat_edge2_valid", 64'(out_valid), 64'd1);
        for (int i = 0; i < 5; i++) step();
        check("post_reset_drained", 64'(q.size()), 64'd0);

        // Random operands, random backpressure and bubbles
        rand_mode = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                in_valid = 1'b0;
                set_ready();
                #1;
                step();
            end
            send_ref(rand_fp(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        rand_mode = 1'b0;
        bp_lo = 0;
        bp_hi = 0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
